// File: rtl/lab7_2_time_setter.sv
// HH:MM preset editor. Digits are edited in place and, on commit, held steady
// while start_stop pulses for LOAD_PULSE cycles so the counter loads them.
module lab7_2_time_setter #(
    parameter int unsigned LOAD_PULSE = 2,
    parameter int unsigned BLINK_DIV  = 2
) (
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic       set_mode,
    input  logic       sel,
    input  logic       inc,
    input  logic       dec,
    input  logic       commit,
    output logic [3:0] l_h1,
    output logic [3:0] l_h2,
    output logic [3:0] l_m1,
    output logic [3:0] l_m2,
    output logic       start_stop,
    output logic [1:0] cursor,
    output logic       blink,
    output logic       editing,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StEdit, StLoad} state_e;

    localparam logic [2:0] PulseLast = 3'(LOAD_PULSE - 1);
    localparam logic [7:0] BlinkLast = 8'(BLINK_DIV - 1);

    state_e     state_q, state_d;
    logic [3:0] dig_q [4];
    logic [3:0] dig_d [4];
    logic [1:0] cursor_q, cursor_d;
    logic [2:0] pulse_q, pulse_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_q, blink_d;
    logic       start_stop_q, busy_q, editing_q;
    logic [3:0] cur_dig, cur_max;

    // Legal maximum of each digit; hour units depend on hour tens.
    function automatic logic [3:0] digit_max(input logic [1:0] idx, input logic [3:0] h1);
        logic [3:0] m;
        unique case (idx)
            2'd0:    m = 4'd2;
            2'd1:    m = (h1 == 4'd2) ? 4'd3 : 4'd9;
            2'd2:    m = 4'd5;
            default: m = 4'd9;
        endcase
        return m;
    endfunction

    assign cur_dig = dig_q[cursor_q];
    assign cur_max = digit_max(cursor_q, dig_q[0]);

    always_comb begin
        state_d     = state_q;
        dig_d       = dig_q;
        cursor_d    = cursor_q;
        pulse_d     = pulse_q;
        blink_d     = 1'b0;
        blink_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (set_mode) begin
                    state_d  = StEdit;
                    cursor_d = 2'd0;
                end
            end
            StEdit: begin
                if (blink_cnt_q == BlinkLast) begin
                    blink_d = ~blink_q;
                end else begin
                    blink_d     = blink_q;
                    blink_cnt_d = blink_cnt_q + 8'd1;
                end
                if (!set_mode) begin
                    state_d = StIdle;
                    blink_d = 1'b0;
                end else if (commit) begin
                    state_d = StLoad;
                    pulse_d = 3'd0;
                    blink_d = 1'b0;
                end else if (sel) begin
                    cursor_d = cursor_q + 2'd1;
                end else if (inc ^ dec) begin
                    if (inc) begin
                        dig_d[cursor_q] = (cur_dig == cur_max) ? 4'd0 : cur_dig + 4'd1;
                    end else begin
                        dig_d[cursor_q] = (cur_dig == 4'd0) ? cur_max : cur_dig - 4'd1;
                    end
                    // Entering the 20s must never leave an illegal 24..29.
                    if (dig_d[0] == 4'd2 && dig_d[1] > 4'd3) begin
                        dig_d[1] = 4'd3;
                    end
                end
            end
            StLoad: begin
                if (pulse_q == PulseLast) begin
                    state_d = StIdle;
                    pulse_d = 3'd0;
                end else begin
                    pulse_d = pulse_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            dig_q[0]     <= 4'd2;
            dig_q[1]     <= 4'd3;
            dig_q[2]     <= 4'd5;
            dig_q[3]     <= 4'd9;
            cursor_q     <= 2'd0;
            pulse_q      <= 3'd0;
            blink_cnt_q  <= 8'd0;
            blink_q      <= 1'b0;
            start_stop_q <= 1'b0;
            busy_q       <= 1'b0;
            editing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dig_q        <= dig_d;
            cursor_q     <= cursor_d;
            pulse_q      <= pulse_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            start_stop_q <= (state_d == StLoad);
            busy_q       <= (state_d == StLoad);
            editing_q    <= (state_d == StEdit);
        end
    end

    assign l_h1       = dig_q[0];
    assign l_h2       = dig_q[1];
    assign l_m1       = dig_q[2];
    assign l_m2       = dig_q[3];
    assign cursor     = cursor_q;
    assign blink      = blink_q;
    assign start_stop = start_stop_q;
    assign busy       = busy_q;
    assign editing    = editing_q;

endmodule

// File: tb/tb_lab7_2_time_setter.sv
// Bench for the preset editor: a per-cycle reference model checked on every
// falling edge, plus directed sequences with literal expectations.
module tb_lab7_2_time_setter;

    localparam int LOAD_PULSE = 2;
    localparam int BLINK_DIV  = 2;

    logic       clk_1 = 1'b0;
    logic       rst_n;
    logic       set_mode, sel, inc, dec, commit;
    logic [3:0] l_h1, l_h2, l_m1, l_m2;
    logic       start_stop, blink, editing, busy;
    logic [1:0] cursor;

    int n_checks = 0;
    int n_fail   = 0;

    lab7_2_time_setter #(.LOAD_PULSE(LOAD_PULSE), .BLINK_DIV(BLINK_DIV)) dut (
        .clk_1(clk_1), .rst_n(rst_n), .set_mode(set_mode), .sel(sel), .inc(inc),
        .dec(dec), .commit(commit), .l_h1(l_h1), .l_h2(l_h2), .l_m1(l_m1),
        .l_m2(l_m2), .start_stop(start_stop), .cursor(cursor), .blink(blink),
        .editing(editing), .busy(busy)
    );

    always #5 clk_1 = ~clk_1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: mode 0=idle, 1=edit, 2=load.
    int m_dig [4];
    int m_mode, m_cur, m_lcnt, m_ecnt;

    function automatic int dmax(input int idx, input int h1);
        if (idx == 0) return 2;
        if (idx == 1) return (h1 == 2) ? 3 : 9;
        if (idx == 2) return 5;
        return 9;
    endfunction

    always @(posedge clk_1 or negedge rst_n) begin : model
        int nd [4];
        int nm, nc, nl, ne, mx;
        if (!rst_n) begin
            m_dig[0] <= 2; m_dig[1] <= 3; m_dig[2] <= 5; m_dig[3] <= 9;
            m_mode <= 0; m_cur <= 0; m_lcnt <= 0; m_ecnt <= 0;
        end else begin
            nd = m_dig; nm = m_mode; nc = m_cur; nl = m_lcnt; ne = m_ecnt;
            if (m_mode == 0) begin
                if (set_mode) begin nm = 1; nc = 0; ne = 0; end
            end else if (m_mode == 1) begin
                ne = m_ecnt + 1;
                if (!set_mode) nm = 0;
                else if (commit) begin nm = 2; nl = 0; end
                else if (sel) nc = (m_cur + 1) % 4;
                else if (inc != dec) begin
                    mx = dmax(m_cur, m_dig[0]);
                    if (inc) nd[m_cur] = (m_dig[m_cur] == mx) ? 0 : m_dig[m_cur] + 1;
                    else     nd[m_cur] = (m_dig[m_cur] == 0) ? mx : m_dig[m_cur] - 1;
                    if (nd[0] == 2 && nd[1] > 3) nd[1] = 3;
                end
            end else begin
                nl = m_lcnt + 1;
                if (nl == LOAD_PULSE) nm = 0;
            end
            m_dig <= nd; m_mode <= nm; m_cur <= nc; m_lcnt <= nl; m_ecnt <= ne;
        end
    end

    always @(negedge clk_1) begin
        if (rst_n) begin
            check("m_l_h1", int'(l_h1), m_dig[0]);
            check("m_l_h2", int'(l_h2), m_dig[1]);
            check("m_l_m1", int'(l_m1), m_dig[2]);
            check("m_l_m2", int'(l_m2), m_dig[3]);
            check("m_cursor", int'(cursor), m_cur);
            check("m_start_stop", int'(start_stop), int'(m_mode == 2));
            check("m_busy", int'(busy), int'(m_mode == 2));
            check("m_editing", int'(editing), int'(m_mode == 1));
            check("m_blink", int'(blink), (m_mode == 1) ? (m_ecnt / BLINK_DIV) % 2 : 0);
        end
    end

    task automatic cyc(input logic sm, input logic s, input logic i, input logic d,
                       input logic c);
        @(negedge clk_1);
        set_mode = sm; sel = s; inc = i; dec = d; commit = c;
        @(posedge clk_1);
        #1;
    endtask

    task automatic check_time(input string name, input int h1, input int h2, input int m1,
                              input int m2);
        check({name, "_h1"}, int'(l_h1), h1);
        check({name, "_h2"}, int'(l_h2), h2);
        check({name, "_m1"}, int'(l_m1), m1);
        check({name, "_m2"}, int'(l_m2), m2);
    endtask

    initial begin
        rst_n = 1'b0;
        set_mode = 0; sel = 0; inc = 0; dec = 0; commit = 0;
        repeat (2) @(posedge clk_1);
        @(negedge clk_1);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);
        check_time("reset", 2, 3, 5, 9);
        check("reset_cursor", int'(cursor), 0);
        check("reset_start_stop", int'(start_stop), 0);
        check("reset_editing", int'(editing), 0);
        cyc(0, 1, 1, 0, 1);
        check_time("idle_ignores", 2, 3, 5, 9);

        // Cursor walk and minute-tens wrap
        cyc(1, 0, 0, 0, 0);
        check("edit_entry", int'(editing), 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("cursor_m1", int'(cursor), 2);
        cyc(1, 0, 1, 0, 0);
        check("m1_wrap_up", int'(l_m1), 0);
        repeat (6) cyc(1, 0, 1, 0, 0);
        check("m1_after_7", int'(l_m1), 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("cursor_wrap", int'(cursor), 0);

        // Hour clamp from 19:09
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (6) cyc(1, 0, 1, 0, 0);
        check_time("preset_19", 1, 9, 0, 9);
        repeat (3) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check_time("clamp", 2, 3, 0, 9);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check("h2_wrap_up", int'(l_h2), 0);
        cyc(1, 0, 0, 1, 0);
        check("h2_wrap_down", int'(l_h2), 3);

        // Build 01:30 and commit
        repeat (3) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(1, 1, 0, 0, 0);
        repeat (3) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        check_time("preset_0130", 0, 1, 3, 0);
        cyc(1, 0, 0, 0, 1);
        check("load1_ss", int'(start_stop), 1);
        check("load1_busy", int'(busy), 1);
        cyc(1, 0, 0, 0, 0);
        check("load2_ss", int'(start_stop), 1);
        cyc(1, 0, 0, 0, 0);
        check("post_load_ss", int'(start_stop), 0);
        check("post_load_busy", int'(busy), 0);
        check("post_load_editing", int'(editing), 0);
        cyc(1, 0, 0, 0, 0);
        check("reenter_edit", int'(editing), 1);
        check("reenter_cursor", int'(cursor), 0);
        check_time("held_0130", 0, 1, 3, 0);

        // Priority and ignored inputs in LOAD
        cyc(1, 1, 1, 0, 1);
        check("prio_load", int'(busy), 1);
        check("prio_cursor", int'(cursor), 0);
        check_time("prio_digits", 0, 1, 3, 0);
        cyc(0, 0, 1, 0, 0);
        check("load_ignores_mode", int'(start_stop), 1);
        cyc(0, 1, 0, 1, 1);
        check("load_done", int'(busy), 0);
        check_time("load_ignored_edits", 0, 1, 3, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 0);
        check("incdec_noop", int'(l_h1), 0);
        cyc(0, 0, 0, 0, 0);
        check("exit_no_load", int'(start_stop), 0);
        check("exit_idle", int'(editing), 0);

        // Async reset in the second LOAD cycle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        check("async_pre_ss", int'(start_stop), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ss", int'(start_stop), 0);
        check("async_busy", int'(busy), 0);
        check_time("async_digits", 2, 3, 5, 9);
        set_mode = 0; commit = 0;
        @(negedge clk_1);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        check("after_reset_ss", int'(start_stop), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
